// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: latch enables/flushes,
// memory-wait and halt-drain sequencing, saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             redirect,
    input  logic             halt_mem,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_enable,
    output logic             idex_flush,
    output logic             exmem_enable,
    output logic             exmem_flush,
    output logic             memwb_enable,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DMEM_WAIT  = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t state, next_state;
    logic   memop, mem_ready, load_use;
    logic   stall_inc, flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign memop     = exmem_dREN | exmem_dWEN;
    assign mem_ready = !memop | dhit;
    assign load_use  = idex_dREN && (idex_wsel != '0) &&
                       ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    assign halted    = (state == HALTED);

    always_comb begin
        pc_enable    = 1'b0;
        ifid_enable  = 1'b0;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b0;
        idex_flush   = 1'b0;
        exmem_enable = 1'b0;
        exmem_flush  = 1'b0;
        memwb_enable = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        next_state   = state;
        // Everything is held low while reset is asserted, regardless of state.
        if (nRST) begin
            case (state)
                RUN, DMEM_WAIT: begin
                    if (!mem_ready) begin
                        stall_inc  = 1'b1;
                        next_state = DMEM_WAIT;
                    end else begin
                        next_state = RUN;
                        if (halt_mem) begin
                            ifid_flush   = 1'b1;
                            idex_flush   = 1'b1;
                            exmem_flush  = 1'b1;
                            memwb_enable = 1'b1;
                            next_state   = HALT_DRAIN;
                        end else if (redirect) begin
                            pc_enable    = 1'b1;
                            ifid_flush   = 1'b1;
                            idex_flush   = 1'b1;
                            exmem_flush  = 1'b1;
                            memwb_enable = 1'b1;
                            flush_inc    = 1'b1;
                        end else if (load_use) begin
                            idex_flush   = 1'b1;
                            exmem_enable = 1'b1;
                            memwb_enable = 1'b1;
                            stall_inc    = 1'b1;
                        end else if (!ihit) begin
                            ifid_flush   = 1'b1;
                            idex_enable  = 1'b1;
                            exmem_enable = 1'b1;
                            memwb_enable = 1'b1;
                            stall_inc    = 1'b1;
                        end else begin
                            pc_enable    = 1'b1;
                            ifid_enable  = 1'b1;
                            idex_enable  = 1'b1;
                            exmem_enable = 1'b1;
                            memwb_enable = 1'b1;
                        end
                    end
                end
                HALT_DRAIN: begin
                    memwb_enable = 1'b1;
                    next_state   = HALTED;
                end
                default: next_state = HALTED;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= next_state;
            if (stall_inc) stall_count <= sat_inc(stall_count);
            if (flush_inc) flush_count <= sat_inc(flush_count);
        end
    end

endmodule
